line_follow_ctrl: RTL and testbench

- Parametrised line-follower motor controller; successor to the fixed 3-sensor combinational steering logic.
- Supports N track sensors with per-sensor debounce, proportional gentle/pivot steering, and a lost-line recovery FSM (hold, search, stop).
- Adds an obstacle stop with hysteresis, driven by the ultrasonic distance.
- Drives the existing motor block's l_mode/r_mode inputs. Mode encoding: 0 off, 1 forward, 2 backward, 3 off.

---
 rtl/line_follow_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl
// ----------------
// Line-follower motor controller. Debounces N_SENS track sensors, steers
// proportionally (gentle turn when the centre sensor still sees the line,
// pivot otherwise), runs a lost-line recovery sequence (hold the last
// command, pivot-search toward the last known side, then stop) and
// forces a stop while an obstacle is latched from the ultrasonic ranger.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   track       raw sensor bits, 1 = line under sensor; [N_SENS-1] is leftmost
//   distance    ultrasonic distance in cm
//   dist_valid  distance is fresh this cycle (single-cycle strobe, no back-pressure)
//   l_mode      left motor mode, registered (0 off, 1 fwd, 2 back, 3 off)
//   r_mode      right motor mode, registered
//   state       FSM state: 0 STOP, 1 FOLLOW, 2 LOST_HOLD, 3 SEARCH, 4 BLOCKED
//   blocked     obstacle latch
module line_follow_ctrl #(
  parameter int N_SENS        = 5,
  parameter int DEBOUNCE      = 4,
  parameter int DIST_W        = 20,
  parameter int STOP_DIST     = 15,
  parameter int HYST          = 5,
  parameter int LOST_HOLD_CYC = 1000,
  parameter int SEARCH_CYC    = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] track,
  input  logic [DIST_W-1:0] distance,
  input  logic              dist_valid,
  output logic [1:0]        l_mode,
  output logic [1:0]        r_mode,
  output logic [2:0]        state,
  output logic              blocked
);

  localparam int C      = (N_SENS - 1) / 2;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HOLD_W = (LOST_HOLD_CYC > 1) ? $clog2(LOST_HOLD_CYC) : 1;
  localparam int SRCH_W = (SEARCH_CYC > 1) ? $clog2(SEARCH_CYC) : 1;
  localparam int CNT_W  = (C > 0) ? $clog2(C + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOST_HOLD_CYC - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_CYC - 1);

  // One extra bit so STOP_DIST+HYST can never alias onto a small distance.
  localparam logic [DIST_W:0] SET_LIM = (DIST_W + 1)'(STOP_DIST);
  localparam logic [DIST_W:0] CLR_LIM = (DIST_W + 1)'(STOP_DIST + HYST);

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_FWD = 2'd1;
  localparam logic [1:0] M_BWD = 2'd2;

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_FOLLOW    = 3'd1,
    ST_LOST_HOLD = 3'd2,
    ST_SEARCH    = 3'd3,
    ST_BLOCKED   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------
  // Per-sensor debounce: a bit's counter runs only while raw disagrees with
  // the filtered value; the DEBOUNCE-th consecutive disagreeing sample
  // updates the filtered bit.
  // ---------------------------------------------------------------------
  logic [N_SENS-1:0] filt_q;
  logic [DB_W-1:0]   db_cnt_q [N_SENS];

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < N_SENS; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SENS; i++) begin
        if (track[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          filt_q[i]   <= track[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Obstacle latch with hysteresis; only fresh distance samples move it.
  // ---------------------------------------------------------------------
  logic blocked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blocked_q <= 1'b0;
    end else if (dist_valid) begin
      if ({1'b0, distance} < SET_LIM)        blocked_q <= 1'b1;
      else if ({1'b0, distance} >= CLR_LIM)  blocked_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Steering terms from the filtered sensors.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] rcnt;
  logic             ctr;
  logic             none;

  always_comb begin
    lcnt = '0;
    rcnt = '0;
    for (int i = C + 1; i < N_SENS; i++) lcnt = lcnt + CNT_W'(filt_q[i]);
    for (int i = 0; i < C; i++)          rcnt = rcnt + CNT_W'(filt_q[i]);
    ctr  = filt_q[C];
    none = (filt_q == '0);
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SRCH_W-1:0] search_q, search_d;
  logic [1:0]        l_mode_q, l_mode_d;
  logic [1:0]        r_mode_q, r_mode_d;
  logic              last_dir_q, last_dir_d;   // 0 left, 1 right

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      hold_q     <= '0;
      search_q   <= '0;
      l_mode_q   <= M_OFF;
      r_mode_q   <= M_OFF;
      last_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      search_q   <= search_d;
      l_mode_q   <= l_mode_d;
      r_mode_q   <= r_mode_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Next state. The obstacle latch pre-empts every state; a reappearing
  // line is tested before the timeouts so it wins on the timeout cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    search_d = search_q;
    if (blocked_q) begin
      state_d  = ST_BLOCKED;
      hold_d   = '0;
      search_d = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (!none) state_d = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          if (none) begin
            state_d = ST_LOST_HOLD;
            hold_d  = '0;
          end
        end
        ST_LOST_HOLD: begin
          if (!none) begin
            state_d = ST_FOLLOW;
          end else if (hold_q == HOLD_LAST) begin
            state_d  = ST_SEARCH;
            search_d = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_SEARCH: begin
          if (!none) begin
            state_d = ST_FOLLOW;
          end else if (search_q == SRCH_LAST) begin
            state_d = ST_STOP;
          end else begin
            search_d = search_q + SRCH_W'(1);
          end
        end
        ST_BLOCKED: begin
          state_d = none ? ST_STOP : ST_FOLLOW;
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  // Motor modes are registered from the state being entered, so they track
  // the same edge's decision.
  always_comb begin
    l_mode_d   = M_OFF;
    r_mode_d   = M_OFF;
    last_dir_d = last_dir_q;
    case (state_d)
      ST_FOLLOW: begin
        if (lcnt == rcnt) begin
          l_mode_d = M_FWD;
          r_mode_d = M_FWD;
        end else if (lcnt > rcnt) begin
          l_mode_d   = ctr ? M_OFF : M_BWD;
          r_mode_d   = M_FWD;
          last_dir_d = 1'b0;
        end else begin
          l_mode_d   = M_FWD;
          r_mode_d   = ctr ? M_OFF : M_BWD;
          last_dir_d = 1'b1;
        end
      end
      ST_LOST_HOLD: begin
        l_mode_d = l_mode_q;
        r_mode_d = r_mode_q;
      end
      ST_SEARCH: begin
        l_mode_d = last_dir_q ? M_FWD : M_BWD;
        r_mode_d = last_dir_q ? M_BWD : M_FWD;
      end
      default: begin
        l_mode_d = M_OFF;
        r_mode_d = M_OFF;
      end
    endcase
  end

  assign l_mode  = l_mode_q;
  assign r_mode  = r_mode_q;
  assign state   = state_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
module tb_line_follow_ctrl;

  localparam int N_SENS    = 5;
  localparam int DEBOUNCE  = 4;
  localparam int DIST_W    = 20;
  localparam int STOP_DIST = 15;
  localparam int HYST      = 5;
  localparam int LOST_HOLD = 10;
  localparam int SEARCH    = 20;
  localparam int C         = (N_SENS - 1) / 2;

  localparam int S_STOP = 0, S_FOLLOW = 1, S_LOST = 2, S_SEARCH = 3, S_BLOCKED = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [N_SENS-1:0] track;
  logic [DIST_W-1:0] distance;
  logic              dist_valid;
  logic [1:0]        l_mode;
  logic [1:0]        r_mode;
  logic [2:0]        state;
  logic              blocked;

  always #5 clk = ~clk;

  line_follow_ctrl #(
    .N_SENS(N_SENS), .DEBOUNCE(DEBOUNCE), .DIST_W(DIST_W),
    .STOP_DIST(STOP_DIST), .HYST(HYST),
    .LOST_HOLD_CYC(LOST_HOLD), .SEARCH_CYC(SEARCH)
  ) dut (
    .clk(clk), .rst(rst), .track(track), .distance(distance),
    .dist_valid(dist_valid), .l_mode(l_mode), .r_mode(r_mode),
    .state(state), .blocked(blocked)
  );

  int n_vec = 0;
  int n_err = 0;

  // Bench-side view of what the motors should currently be doing.
  logic [1:0] cur_l, cur_r;
  logic       dir_right;     // last side the line was seen on
  logic [3:0] exp_q[$];      // expected {l,r} per steering pattern

  // ---------------- reference model ----------------
  // Steering from the sensor picture: count lit sensors on each side of
  // centre; equal -> straight, otherwise turn toward the heavier side,
  // gently if the centre still sees the line, else pivot.
  function automatic logic [3:0] steer_model(input logic [N_SENS-1:0] t);
    int l, r;
    l = 0;
    r = 0;
    for (int i = 0; i < N_SENS; i++) begin
      if (i > C) l += int'(t[i]);
      if (i < C) r += int'(t[i]);
    end
    if (l == r)     return {2'd1, 2'd1};
    else if (l > r) return t[C] ? {2'd0, 2'd1} : {2'd2, 2'd1};
    else            return t[C] ? {2'd1, 2'd0} : {2'd1, 2'd2};
  endfunction

  // +1 line heavier on the right, -1 heavier on the left, 0 balanced.
  function automatic int side_of(input logic [N_SENS-1:0] t);
    int l, r;
    l = 0;
    r = 0;
    for (int i = 0; i < N_SENS; i++) begin
      if (i > C) l += int'(t[i]);
      if (i < C) r += int'(t[i]);
    end
    return (r > l) ? 1 : (l > r) ? -1 : 0;
  endfunction

  function automatic logic [3:0] pivot_model(input logic right);
    return right ? {2'd1, 2'd2} : {2'd2, 2'd1};
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; track = '0; distance = '0; dist_valid = 1'b0;
    tick(2);
    if ({l_mode, r_mode} !== 4'b0000) begin
      $display("FAIL reset_modes: got %0d/%0d want 0/0", l_mode, r_mode); n_err++;
    end
    n_vec++;
    if (state !== 3'(S_STOP)) begin
      $display("FAIL reset_state: got %0d want %0d", state, S_STOP); n_err++;
    end
    n_vec++;
    if (blocked !== 1'b0) begin
      $display("FAIL reset_blocked: got %0d want 0", blocked); n_err++;
    end
    n_vec++;
    rst = 1'b0;
    cur_l = 2'd0; cur_r = 2'd0; dir_right = 1'b0;
  endtask

  task automatic test_center_and_glitch();
    track = 5'b00100;
    tick(DEBOUNCE);
    if (state !== 3'(S_STOP) || {l_mode, r_mode} !== 4'b0000) begin
      $display("FAIL center_early: got st=%0d %0d/%0d want st=0 0/0", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
    tick(1);
    if (state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
      $display("FAIL center_follow: got st=%0d %0d/%0d want st=1 1/1", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
    cur_l = 2'd1; cur_r = 2'd1;
    // glitches shorter than the debounce window must be ignored
    for (int g = 0; g < 6; g++) begin
      int b, len;
      b   = (g == 0) ? 4 : $urandom_range(0, N_SENS - 1);
      len = (g == 0) ? 3 : $urandom_range(1, DEBOUNCE - 1);
      track[b] = ~track[b];
      tick(len);
      track[b] = ~track[b];
      for (int k = 0; k < DEBOUNCE + 1; k++) begin
        tick(1);
        if ({l_mode, r_mode} !== {cur_l, cur_r} || state !== 3'(S_FOLLOW)) begin
          $display("FAIL glitch bit%0d len%0d: got st=%0d %0d/%0d want st=1 %0d/%0d",
                   b, len, state, l_mode, r_mode, cur_l, cur_r); n_err++;
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_steer();
    logic [N_SENS-1:0] pats[$];
    pats.push_back(5'b01100);
    pats.push_back(5'b01000);
    pats.push_back(5'b00110);
    pats.push_back(5'b00010);
    for (int i = 0; i < 16; i++) pats.push_back(N_SENS'($urandom_range(1, (1 << N_SENS) - 1)));
    foreach (pats[i]) exp_q.push_back(steer_model(pats[i]));
    foreach (pats[i]) begin
      logic [3:0] exp;
      exp = exp_q.pop_front();
      track = pats[i];
      tick(DEBOUNCE);
      if ({l_mode, r_mode} !== {cur_l, cur_r}) begin
        $display("FAIL steer_hold %b: got %0d/%0d want %0d/%0d",
                 pats[i], l_mode, r_mode, cur_l, cur_r); n_err++;
      end
      n_vec++;
      tick(1);
      if ({l_mode, r_mode} !== exp || state !== 3'(S_FOLLOW)) begin
        $display("FAIL steer %b: got st=%0d %0d/%0d want st=1 %0d/%0d",
                 pats[i], state, l_mode, r_mode, exp[3:2], exp[1:0]); n_err++;
      end
      n_vec++;
      {cur_l, cur_r} = exp;
      if (side_of(pats[i]) > 0) dir_right = 1'b1;
      else if (side_of(pats[i]) < 0) dir_right = 1'b0;
    end
  endtask

  task automatic test_lost_line();
    logic [3:0] exp;
    int         es;
    track = 5'b01000;
    tick(DEBOUNCE + 1);
    exp = steer_model(5'b01000);
    if ({l_mode, r_mode} !== exp) begin
      $display("FAIL lost_setup: got %0d/%0d want %0d/%0d", l_mode, r_mode, exp[3:2], exp[1:0]); n_err++;
    end
    n_vec++;
    {cur_l, cur_r} = exp;
    dir_right = 1'b0;
    track = '0;
    for (int k = 1; k <= DEBOUNCE + LOST_HOLD + SEARCH + 4; k++) begin
      tick(1);
      if (k <= DEBOUNCE) begin
        es = S_FOLLOW; exp = {cur_l, cur_r};
      end else if (k <= DEBOUNCE + LOST_HOLD) begin
        es = S_LOST; exp = {cur_l, cur_r};
      end else if (k <= DEBOUNCE + LOST_HOLD + SEARCH) begin
        es = S_SEARCH; exp = pivot_model(dir_right);
      end else begin
        es = S_STOP; exp = 4'b0000;
      end
      if (state !== 3'(es) || {l_mode, r_mode} !== exp) begin
        $display("FAIL lost_seq k=%0d: got st=%0d %0d/%0d want st=%0d %0d/%0d",
                 k, state, l_mode, r_mode, es, exp[3:2], exp[1:0]); n_err++;
      end
      n_vec++;
    end
    track = 5'b00100;
    tick(DEBOUNCE + 1);
    if (state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
      $display("FAIL lost_recover: got st=%0d %0d/%0d want st=1 1/1", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
    cur_l = 2'd1; cur_r = 2'd1;
  endtask

  task automatic test_obstacle();
    int  dists[3];
    int  exp_b[3];
    logic model_b, prev_b;
    dists = '{14, 17, 20};
    exp_b = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      dist_valid = 1'b1; distance = DIST_W'(dists[i]);
      tick(1);
      dist_valid = 1'b0;
      if (blocked !== 1'(exp_b[i])) begin
        $display("FAIL obst_latch d=%0d: got %0d want %0d", dists[i], blocked, exp_b[i]); n_err++;
      end
      n_vec++;
      tick(1);
      if (exp_b[i] == 1) begin
        if (state !== 3'(S_BLOCKED) || {l_mode, r_mode} !== 4'b0000) begin
          $display("FAIL obst_state d=%0d: got st=%0d %0d/%0d want st=4 0/0",
                   dists[i], state, l_mode, r_mode); n_err++;
        end
      end else begin
        if (state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
          $display("FAIL obst_state d=%0d: got st=%0d %0d/%0d want st=1 1/1",
                   dists[i], state, l_mode, r_mode); n_err++;
        end
      end
      n_vec++;
    end
    // random sweep around the thresholds against a plain hysteresis latch
    model_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int d;
      logic dv;
      dv = 1'($urandom_range(0, 1));
      d  = (i % 3 == 0) ? $urandom_range(STOP_DIST - 1, STOP_DIST + HYST) : $urandom_range(0, 40);
      dist_valid = dv; distance = DIST_W'(d);
      prev_b = model_b;
      if (dv && d < STOP_DIST) model_b = 1'b1;
      else if (dv && d >= STOP_DIST + HYST) model_b = 1'b0;
      tick(1);
      if (blocked !== model_b) begin
        $display("FAIL obst_sweep d=%0d v=%0d: got %0d want %0d", d, dv, blocked, model_b); n_err++;
      end
      n_vec++;
      if (state !== 3'(prev_b ? S_BLOCKED : S_FOLLOW) ||
          {l_mode, r_mode} !== (prev_b ? 4'b0000 : 4'b0101)) begin
        $display("FAIL obst_sweep_state i=%0d: got st=%0d %0d/%0d want blocked=%0d",
                 i, state, l_mode, r_mode, prev_b); n_err++;
      end
      n_vec++;
    end
    dist_valid = 1'b1; distance = DIST_W'(30);
    tick(1);
    dist_valid = 1'b0;
    tick(1);
    if (blocked !== 1'b0 || state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
      $display("FAIL obst_release: got b=%0d st=%0d %0d/%0d want b=0 st=1 1/1",
               blocked, state, l_mode, r_mode); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_collision();
    logic [3:0] piv;
    piv = pivot_model(dir_right);
    track = '0;
    tick(DEBOUNCE + LOST_HOLD + 2);
    if (state !== 3'(S_SEARCH) || {l_mode, r_mode} !== piv) begin
      $display("FAIL coll_search: got st=%0d %0d/%0d want st=3 %0d/%0d",
               state, l_mode, r_mode, piv[3:2], piv[1:0]); n_err++;
    end
    n_vec++;
    track = 5'b00100;
    tick(DEBOUNCE - 1);
    dist_valid = 1'b1; distance = DIST_W'(10);
    tick(1);                      // filtered line and obstacle arrive together
    dist_valid = 1'b0;
    if (blocked !== 1'b1 || state !== 3'(S_SEARCH)) begin
      $display("FAIL coll_edge: got b=%0d st=%0d want b=1 st=3", blocked, state); n_err++;
    end
    n_vec++;
    tick(1);
    if (state !== 3'(S_BLOCKED) || {l_mode, r_mode} !== 4'b0000) begin
      $display("FAIL coll_blocked: got st=%0d %0d/%0d want st=4 0/0", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
    dist_valid = 1'b1; distance = DIST_W'(25);
    tick(1);
    dist_valid = 1'b0;
    tick(1);
    if (state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
      $display("FAIL coll_release: got st=%0d %0d/%0d want st=1 1/1", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid_search();
    logic [3:0] exp;
    track = 5'b00010;
    tick(DEBOUNCE + 1);
    exp = steer_model(5'b00010);
    dir_right = 1'b1;
    if ({l_mode, r_mode} !== exp) begin
      $display("FAIL rstm_setup: got %0d/%0d want %0d/%0d", l_mode, r_mode, exp[3:2], exp[1:0]); n_err++;
    end
    n_vec++;
    track = '0;
    tick(DEBOUNCE + LOST_HOLD + 2);
    exp = pivot_model(dir_right);
    if (state !== 3'(S_SEARCH) || {l_mode, r_mode} !== exp) begin
      $display("FAIL rstm_search: got st=%0d %0d/%0d want st=3 %0d/%0d",
               state, l_mode, r_mode, exp[3:2], exp[1:0]); n_err++;
    end
    n_vec++;
    rst = 1'b1; dist_valid = 1'b1; distance = DIST_W'(5);
    tick(1);
    rst = 1'b0; dist_valid = 1'b0;
    dir_right = 1'b0;
    if (state !== 3'(S_STOP) || {l_mode, r_mode} !== 4'b0000 || blocked !== 1'b0) begin
      $display("FAIL rstm_reset: got st=%0d %0d/%0d b=%0d want st=0 0/0 b=0",
               state, l_mode, r_mode, blocked); n_err++;
    end
    n_vec++;
    track = 5'b00100;
    tick(DEBOUNCE + 1);
    if (state !== 3'(S_FOLLOW) || {l_mode, r_mode} !== 4'b0101) begin
      $display("FAIL rstm_follow: got st=%0d %0d/%0d want st=1 1/1", state, l_mode, r_mode); n_err++;
    end
    n_vec++;
    track = '0;
    tick(DEBOUNCE + LOST_HOLD + 2);
    exp = pivot_model(dir_right);
    if (state !== 3'(S_SEARCH) || {l_mode, r_mode} !== exp) begin
      $display("FAIL rstm_lastdir: got st=%0d %0d/%0d want st=3 %0d/%0d",
               state, l_mode, r_mode, exp[3:2], exp[1:0]); n_err++;
    end
    n_vec++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; track = '0; distance = '0; dist_valid = 1'b0;
    test_reset();
    test_center_and_glitch();
    test_steer();
    test_lost_line();
    test_obstacle();
    test_collision();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
